// File: rtl/hms_counter_pkg.sv
// Shared types and helpers for the hours:minutes:seconds counter.
// Field width, bus width, FSM state, field bundle, clamp and packed-decimal conversion.
package hms_pkg;

   localparam int FIELD_W = 8;
   localparam int NUM_W   = 24;

   typedef enum logic {
      COUNT   = 1'b0,
      EXPIRED = 1'b1
   } hms_state_t;

   typedef struct packed {
      logic [FIELD_W-1:0] hours;
      logic [FIELD_W-1:0] minutes;
      logic [FIELD_W-1:0] seconds;
   } hms_t;

   // Presets at or above the modulus saturate to the largest legal value.
   function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] v,
                                                      input int modulus);
      return (int'(v) >= modulus) ? FIELD_W'(modulus - 1) : v;
   endfunction

   function automatic logic [NUM_W-1:0] to_number(input hms_t t);
      return NUM_W'(t.hours) * NUM_W'(10000)
           + NUM_W'(t.minutes) * NUM_W'(100)
           + NUM_W'(t.seconds);
   endfunction

endpackage

// File: rtl/hms_counter_if.sv
// Control and display bus of hms_counter.
// The master drives tick/run/down/load and presets; the slave returns fields and strobes.
interface hms_counter_if;
   import hms_pkg::*;

   logic               tick;
   logic               run;
   logic               down;
   logic               load;
   logic [FIELD_W-1:0] load_h;
   logic [FIELD_W-1:0] load_m;
   logic [FIELD_W-1:0] load_s;
   logic [FIELD_W-1:0] hours;
   logic [FIELD_W-1:0] minutes;
   logic [FIELD_W-1:0] seconds;
   logic [NUM_W-1:0]   number;
   logic               rollover;
   logic               done;
   logic               expired;

   modport master (
      output tick, run, down, load, load_h, load_m, load_s,
      input  hours, minutes, seconds, number, rollover, done, expired
   );

   modport slave (
      input  tick, run, down, load, load_h, load_m, load_s,
      output hours, minutes, seconds, number, rollover, done, expired
   );

endinterface

// File: rtl/hms_counter_field.sv
// One modulo-MOD up/down digit field with preset load.
// carry is combinational so a chain of fields advances together in one cycle.
module mod_field_counter
   import hms_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               down,
   input  logic               load,
   input  logic [FIELD_W-1:0] load_val,
   output logic [FIELD_W-1:0] value,
   output logic               carry
);

   localparam logic [FIELD_W-1:0] MAX_VAL = FIELD_W'(MOD - 1);

   logic [FIELD_W-1:0] value_q;
   logic [FIELD_W-1:0] value_d;

   always_comb begin
      carry   = en && (down ? (value_q == '0) : (value_q == MAX_VAL));
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (en) begin
         if (down) begin
            value_d = (value_q == '0) ? MAX_VAL : value_q - FIELD_W'(1);
         end else begin
            value_d = (value_q == MAX_VAL) ? '0 : value_q + FIELD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/hms_counter.sv
// Parametrised hh:mm:ss up/down counter with preset, countdown expiry and strobes.
// Fields are a carry chain of mod_field_counter; number is registered from the fields.
module hms_counter
   import hms_pkg::*;
#(
   parameter int HOUR_MOD     = 24,
   parameter int MIN_MOD      = 60,
   parameter int SEC_MOD      = 60,
   parameter bit STOP_AT_ZERO = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   hms_counter_if.slave bus
);

   hms_state_t       state_q, state_d;
   logic             rollover_q, rollover_d;
   logic             done_q, done_d;
   logic [NUM_W-1:0] number_q, number_d;

   hms_t preset;
   hms_t cur;
   logic counted;
   logic hold_zero;
   logic sec_en;

   // Index 0 = seconds, 1 = minutes, 2 = hours, so the packed order matches hms_t.
   logic [2:0]              en_v;
   logic [2:0]              carry_v;
   logic [2:0][FIELD_W-1:0] load_v;
   logic [2:0][FIELD_W-1:0] val_v;

   assign load_v = preset;
   assign cur    = val_v;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_field
         localparam int FIELD_MOD = (gi == 0) ? SEC_MOD : (gi == 1) ? MIN_MOD : HOUR_MOD;
         if (gi == 0) begin : g_first
            assign en_v[gi] = sec_en;
         end else begin : g_chain
            assign en_v[gi] = carry_v[gi-1];
         end
         mod_field_counter #(.MOD(FIELD_MOD)) u_field (
            .clk      (clk),
            .rst      (rst),
            .en       (en_v[gi]),
            .down     (bus.down),
            .load     (bus.load),
            .load_val (load_v[gi]),
            .value    (val_v[gi]),
            .carry    (carry_v[gi])
         );
      end
   endgenerate

   always_comb begin
      preset.hours   = clamp_field(bus.load_h, HOUR_MOD);
      preset.minutes = clamp_field(bus.load_m, MIN_MOD);
      preset.seconds = clamp_field(bus.load_s, SEC_MOD);

      counted   = bus.tick && bus.run && (state_q == COUNT) && !bus.load;
      hold_zero = STOP_AT_ZERO && bus.down && (cur == '0);
      sec_en    = counted && !hold_zero;

      // A full-chain carry only happens on a wrap in either direction.
      rollover_d = carry_v[2];
      // The only down step that lands on zero starts from 00:00:01.
      done_d = STOP_AT_ZERO && sec_en && bus.down
            && (cur.hours == '0) && (cur.minutes == '0)
            && (cur.seconds == FIELD_W'(1));

      state_d = state_q;
      if (bus.load) begin
         state_d = COUNT;
      end else if (done_d) begin
         state_d = EXPIRED;
      end

      number_d = to_number(cur);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= COUNT;
         rollover_q <= 1'b0;
         done_q     <= 1'b0;
         number_q   <= '0;
      end else begin
         state_q    <= state_d;
         rollover_q <= rollover_d;
         done_q     <= done_d;
         number_q   <= number_d;
      end
   end

   assign bus.hours    = cur.hours;
   assign bus.minutes  = cur.minutes;
   assign bus.seconds  = cur.seconds;
   assign bus.number   = number_q;
   assign bus.rollover = rollover_q;
   assign bus.done     = done_q;
   assign bus.expired  = (state_q == EXPIRED);

endmodule

// File: tb/tb_hms_counter.sv
// Bench for hms_counter: a 24 h stop-at-zero instance and a 12 h wrapping instance
// driven identically, checked by directed scenarios and a total-seconds reference model.
module tb_hms_counter;
   import hms_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hms_counter_if ia ();
   hms_counter_if ib ();

   hms_counter #(.HOUR_MOD(24), .MIN_MOD(60), .SEC_MOD(60), .STOP_AT_ZERO(1'b1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ia.slave)
   );

   hms_counter #(.HOUR_MOD(12), .MIN_MOD(60), .SEC_MOD(60), .STOP_AT_ZERO(1'b0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ib.slave)
   );

   int n_pass   = 0;
   int n_checks = 0;

   // Reference model: the time is one integer count of seconds modulo the period.
   int hmod  [2] = '{24, 12};
   bit stopz [2] = '{1'b1, 1'b0};
   int m_t    [2];
   bit m_exp  [2];
   bit m_roll [2];
   bit m_done [2];
   int m_num  [2];

   function automatic int m_h(int id); return m_t[id] / 3600;       endfunction
   function automatic int m_m(int id); return (m_t[id] / 60) % 60;  endfunction
   function automatic int m_s(int id); return m_t[id] % 60;         endfunction

   function automatic logic [23:0] m_fields(int id);
      return {8'(m_h(id)), 8'(m_m(id)), 8'(m_s(id))};
   endfunction

   task automatic model_update(int id);
      int total;
      int prev_num;
      int h, m, s;
      total     = hmod[id] * 3600;
      prev_num  = m_h(id) * 10000 + m_m(id) * 100 + m_s(id);
      m_roll[id] = 1'b0;
      m_done[id] = 1'b0;
      if (rst) begin
         m_t[id]   = 0;
         m_exp[id] = 1'b0;
         m_num[id] = 0;
      end else begin
         m_num[id] = prev_num;
         if (ia.load) begin
            h = (int'(ia.load_h) >= hmod[id]) ? hmod[id] - 1 : int'(ia.load_h);
            m = (int'(ia.load_m) >= 60) ? 59 : int'(ia.load_m);
            s = (int'(ia.load_s) >= 60) ? 59 : int'(ia.load_s);
            m_t[id]   = (h * 60 + m) * 60 + s;
            m_exp[id] = 1'b0;
         end else if (ia.tick && ia.run && !m_exp[id]) begin
            if (!ia.down) begin
               m_t[id] = m_t[id] + 1;
               if (m_t[id] == total) begin
                  m_t[id]    = 0;
                  m_roll[id] = 1'b1;
               end
            end else if (m_t[id] == 0) begin
               if (!stopz[id]) begin
                  m_t[id]    = total - 1;
                  m_roll[id] = 1'b1;
               end
            end else begin
               m_t[id] = m_t[id] - 1;
               if (m_t[id] == 0 && stopz[id]) begin
                  m_exp[id]  = 1'b1;
                  m_done[id] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic drive(bit r, bit tk, bit rn, bit dn, bit ld, int h = 0, int m = 0, int s = 0);
      rst       = r;
      ia.tick   = tk;  ib.tick   = tk;
      ia.run    = rn;  ib.run    = rn;
      ia.down   = dn;  ib.down   = dn;
      ia.load   = ld;  ib.load   = ld;
      ia.load_h = 8'(h); ib.load_h = 8'(h);
      ia.load_m = 8'(m); ib.load_m = 8'(m);
      ia.load_s = 8'(s); ib.load_s = 8'(s);
   endtask

   task automatic step();
      @(posedge clk);
      model_update(0);
      model_update(1);
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 1, 0, 0);
      step();
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds, ia.number} !== 48'd0)
         $display("FAIL reset_a got %0d:%0d:%0d num=%0d exp 0:0:0 num=0", ia.hours, ia.minutes, ia.seconds, ia.number);
      else n_pass++;
      n_checks++;
      if ({ia.rollover, ia.done, ia.expired, ib.rollover, ib.done, ib.expired} !== 6'b0)
         $display("FAIL reset_flags got a=%b%b%b b=%b%b%b exp 000", ia.rollover, ia.done, ia.expired, ib.rollover, ib.done, ib.expired);
      else n_pass++;
   endtask

   task automatic test_count_up();
      drive(0, 1, 1, 0, 0);
      repeat (3) step();
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds} !== {8'd0, 8'd0, 8'd3})
         $display("FAIL up3_fields got %0d:%0d:%0d exp 0:0:3", ia.hours, ia.minutes, ia.seconds);
      else n_pass++;
      drive(0, 0, 1, 0, 0);
      step();
      n_checks++;
      if (ia.number !== 24'd3) $display("FAIL up3_number got %0d exp 3", ia.number);
      else n_pass++;
   endtask

   task automatic test_rollover();
      drive(0, 0, 1, 0, 1, 23, 59, 58);
      step();
      drive(0, 1, 1, 0, 0);
      step();
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds, ia.rollover} !== {8'd23, 8'd59, 8'd59, 1'b0})
         $display("FAIL roll_pre got %0d:%0d:%0d r=%b exp 23:59:59 r=0", ia.hours, ia.minutes, ia.seconds, ia.rollover);
      else n_pass++;
      step();
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds, ia.rollover, ia.done} !== {24'd0, 1'b1, 1'b0})
         $display("FAIL roll_wrap got %0d:%0d:%0d r=%b d=%b exp 0:0:0 r=1 d=0", ia.hours, ia.minutes, ia.seconds, ia.rollover, ia.done);
      else n_pass++;
      n_checks++;
      if (ia.number !== 24'd235959) $display("FAIL roll_num_lag got %0d exp 235959", ia.number);
      else n_pass++;
      drive(0, 0, 1, 0, 0);
      step();
      n_checks++;
      if ({ia.number, ia.rollover} !== {24'd0, 1'b0})
         $display("FAIL roll_after got num=%0d r=%b exp num=0 r=0", ia.number, ia.rollover);
      else n_pass++;
   endtask

   task automatic test_countdown();
      drive(0, 0, 1, 1, 1, 0, 1, 0);
      step();
      drive(0, 1, 1, 1, 0);
      step();
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds} !== {8'd0, 8'd0, 8'd59})
         $display("FAIL down_borrow got %0d:%0d:%0d exp 0:0:59", ia.hours, ia.minutes, ia.seconds);
      else n_pass++;
      repeat (58) step();
      n_checks++;
      if ({ia.seconds, ia.done, ia.expired} !== {8'd1, 1'b0, 1'b0})
         $display("FAIL down_one got s=%0d d=%b e=%b exp s=1 d=0 e=0", ia.seconds, ia.done, ia.expired);
      else n_pass++;
      step();
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds, ia.done, ia.expired, ia.rollover} !== {24'd0, 1'b1, 1'b1, 1'b0})
         $display("FAIL down_expire got %0d:%0d:%0d d=%b e=%b r=%b exp 0:0:0 d=1 e=1 r=0", ia.hours, ia.minutes, ia.seconds, ia.done, ia.expired, ia.rollover);
      else n_pass++;
      repeat (3) step();
      drive(0, 1, 1, 0, 0);
      step();
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds, ia.done, ia.expired, ia.rollover} !== {24'd0, 1'b0, 1'b1, 1'b0})
         $display("FAIL expired_hold got %0d:%0d:%0d d=%b e=%b r=%b exp 0:0:0 d=0 e=1 r=0", ia.hours, ia.minutes, ia.seconds, ia.done, ia.expired, ia.rollover);
      else n_pass++;
   endtask

   task automatic test_reset_in_expired();
      drive(1, 1, 1, 1, 0);
      step();
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds, ia.number, ia.rollover, ia.done, ia.expired} !== 51'd0)
         $display("FAIL rst_expired got %0d:%0d:%0d num=%0d r=%b d=%b e=%b exp all 0", ia.hours, ia.minutes, ia.seconds, ia.number, ia.rollover, ia.done, ia.expired);
      else n_pass++;
      drive(0, 0, 1, 0, 1, 1, 2, 3);
      step();
      drive(0, 1, 0, 0, 0);
      repeat (5) step();
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds, ia.number} !== {8'd1, 8'd2, 8'd3, 24'd10203})
         $display("FAIL run_low got %0d:%0d:%0d num=%0d exp 1:2:3 num=10203", ia.hours, ia.minutes, ia.seconds, ia.number);
      else n_pass++;
   endtask

   task automatic test_wrap_down();
      drive(0, 0, 1, 1, 1, 0, 0, 0);
      step();
      drive(0, 1, 1, 1, 0);
      step();
      n_checks++;
      if ({ib.hours, ib.minutes, ib.seconds, ib.rollover, ib.done, ib.expired} !== {8'd11, 8'd59, 8'd59, 3'b100})
         $display("FAIL wrap_down_b got %0d:%0d:%0d r=%b d=%b e=%b exp 11:59:59 r=1 d=0 e=0", ib.hours, ib.minutes, ib.seconds, ib.rollover, ib.done, ib.expired);
      else n_pass++;
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds, ia.rollover, ia.done, ia.expired} !== {24'd0, 3'b000})
         $display("FAIL stop_zero_a got %0d:%0d:%0d r=%b d=%b e=%b exp 0:0:0 r=0 d=0 e=0", ia.hours, ia.minutes, ia.seconds, ia.rollover, ia.done, ia.expired);
      else n_pass++;
   endtask

   task automatic test_clamp();
      drive(0, 0, 1, 0, 1, 30, 75, 99);
      step();
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds, ib.hours} !== {8'd23, 8'd59, 8'd59, 8'd11})
         $display("FAIL clamp got a=%0d:%0d:%0d b_h=%0d exp a=23:59:59 b_h=11", ia.hours, ia.minutes, ia.seconds, ib.hours);
      else n_pass++;
      drive(0, 1, 1, 0, 1, 0, 0, 10);
      step();
      n_checks++;
      if ({ia.hours, ia.minutes, ia.seconds, ia.rollover} !== {8'd0, 8'd0, 8'd10, 1'b0})
         $display("FAIL load_tick got %0d:%0d:%0d r=%b exp 0:0:10 r=0", ia.hours, ia.minutes, ia.seconds, ia.rollover);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [23:0] f;
      logic [23:0] num;
      logic [2:0]  fl;
      int h, m, s;
      drive(1, 0, 1, 0, 0);
      step();
      for (int c = 0; c < 800; c++) begin
         h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 110) : $urandom_range(0, 1);
         m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 110) : $urandom_range(0, 1);
         s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 110) : $urandom_range(0, 4);
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) != 0,
               $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, h, m, s);
         step();
         for (int id = 0; id < 2; id++) begin
            if (id == 0) begin
               f = {ia.hours, ia.minutes, ia.seconds}; num = ia.number; fl = {ia.rollover, ia.done, ia.expired};
            end else begin
               f = {ib.hours, ib.minutes, ib.seconds}; num = ib.number; fl = {ib.rollover, ib.done, ib.expired};
            end
            n_checks++;
            if (f !== m_fields(id))
               $display("FAIL rand_fields dut%0d cyc%0d got %0d:%0d:%0d exp %0d:%0d:%0d", id, c, f[23:16], f[15:8], f[7:0], m_h(id), m_m(id), m_s(id));
            else n_pass++;
            n_checks++;
            if (num !== 24'(m_num[id])) $display("FAIL rand_number dut%0d cyc%0d got %0d exp %0d", id, c, num, m_num[id]);
            else n_pass++;
            n_checks++;
            if (fl !== {m_roll[id], m_done[id], m_exp[id]})
               $display("FAIL rand_flags dut%0d cyc%0d got r/d/e=%b exp %b", id, c, fl, {m_roll[id], m_done[id], m_exp[id]});
            else n_pass++;
         end
      end
   endtask

   initial begin
      drive(1, 0, 0, 0, 0);
      @(negedge clk);
      test_reset();
      test_count_up();
      test_rollover();
      test_countdown();
      test_reset_in_expired();
      test_wrap_down();
      test_clamp();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hms_counter.md
# hms_counter

Parametrised hours:minutes:seconds counter; the successor to the fixed 24 h up-only timer. One clock domain: seconds advance on a one-cycle `tick` enable instead of a separate clock, so all carries are evaluated on the current value. Adds up/down counting, synchronous preset load, a configurable hour modulus, a countdown-expiry state and rollover/done strobes. Drives the packed-decimal `number` bus consumed by the display path.

## Interface
- `HOUR_MOD`, 24: hour field modulus; legal range 2..99 (24 or 12 in practice).
- `MIN_MOD`, 60: minute field modulus; legal range 2..99.
- `SEC_MOD`, 60: second field modulus; legal range 2..99.
- `STOP_AT_ZERO`, 1: 1 = down-count stops and expires at 00:00:00; 0 = down-count wraps.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: **synchronous, active-high** reset.
- `tick` in 1: one-cycle count enable, nominally 1 Hz.
- `run` in 1: level; ticks are ignored while low.
- `down` in 1: 0 = count up, 1 = count down; sampled on each tick.
- `load` in 1: one-cycle preset strobe.
- `load_h`, `load_m`, `load_s` in 8 each: preset values.
- `hours`, `minutes`, `seconds` out 8 each: registered binary fields.
- `number` out 24: registered value of hours·10000 + minutes·100 + seconds.
- `rollover` out 1: one-cycle pulse when the counter wraps.
- `done` out 1: one-cycle pulse on entering EXPIRED.
- `expired` out 1: high while in EXPIRED.

## Operation
- The FSM has two states: COUNT and EXPIRED. Reset state is COUNT.
- Priority per cycle: `rst` > `load` > counted tick. A counted tick is `tick && run` while in COUNT.
- **Load**
  - Each field is clamped: a value ≥ its modulus is stored as modulus−1.
  - The FSM goes to COUNT.
  - Load never produces `done` or `rollover`.
- **Up tick**
  - seconds+1. When seconds = SEC_MOD−1, seconds→0 and carry into minutes.
  - The same rule cascades to minutes and then hours.
  - HOUR_MOD−1 : MIN_MOD−1 : SEC_MOD−1 → 00:00:00, and `rollover` pulses.
- **Down tick**
  - seconds−1. When seconds = 0, seconds→SEC_MOD−1 and borrow from minutes; the same rule cascades to hours.
  - Reaching 00:00:00 from a nonzero value with STOP_AT_ZERO=1: go to EXPIRED and pulse `done`.
  - A down tick at 00:00:00 with STOP_AT_ZERO=1: no change, no pulse.
  - A down tick at 00:00:00 with STOP_AT_ZERO=0: the counter becomes HOUR_MOD−1 : MIN_MOD−1 : SEC_MOD−1 and `rollover` pulses.
- **EXPIRED**
  - All ticks are ignored, in either direction.
  - Exited only by `load` (to COUNT) or `rst`.
- **Inputs**
  - Changes of `down` or `run` between ticks take effect at the next tick.
  - `tick` held high counts once per cycle.
- **Arithmetic**
  - `number` is an unsigned 24-bit value built from zero-extended fields.
  - Maximum 99·10000 + 99·100 + 99 = 999999, which is < 2^24, so no overflow.

## Timing
- **Reset** (the cycle after `rst` is sampled high):
  - fields = 0, `number` = 0;
  - `rollover` = `done` = `expired` = 0;
  - state = COUNT.
- Fields update on the clock edge that samples a counted tick or `load` (latency 1).
- `number` is registered from the field registers: it is valid one cycle after the fields, two cycles after `tick`/`load`.
- `rollover` and `done` are asserted in the same cycle the new field values appear, for exactly one cycle.
- `expired` rises with `done`. It falls one cycle after a sampled `load`.
- `load` and `tick` in the same cycle: the load value is stored and the tick is dropped, with no carry applied.
- `rst` during an active tick or load: reset wins.

## Structure
- Shared package `hms_pkg`:
  - `FIELD_W = 8`, `NUM_W = 24`;
  - the `hms_state_t` enum {COUNT, EXPIRED};
  - the `hms_t` struct {hours, minutes, seconds}.
- Sub-module `mod_field_counter`: parameter MOD. Inputs `en`, `down`, `load`, `load_val`. Outputs `value`, plus a combinational `carry` that is high when en && (up ? value==MOD−1 : value==0).
- Three instances are chained: each field's `en` is the previous field's `carry`.
- `hms_counter` owns the FSM, the clamp logic, the strobes and the `number` register.

## Test plan
- `rst`, then 3 ticks up → fields 00:00:03; `number` = 3 two cycles after the last tick.
- Load 23:59:58, 2 up ticks → 23:59:59, then 00:00:00 with a single `rollover` pulse; `number` 235959 → 0.
- Load 00:01:00, `down`=1, 1 tick → 00:00:59. Then 59 ticks → 00:00:00 with `done` and `expired` = 1. Further ticks leave 00:00:00 with no pulses.
- STOP_AT_ZERO=0, HOUR_MOD=12: load 00:00:00, 1 down tick → 11:59:59 and `rollover` pulses, `done` stays 0.
- Load 30:75:99 → clamped to 23:59:59. Then `load`(00:00:10) and `tick` in the same cycle → 00:00:10, tick ignored.
- In EXPIRED, assert `rst` mid-tick → all outputs 0, state COUNT. `run`=0 with 5 ticks → no change.
